// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA timing slice.
//   - Default 640x480@60 Hz timing (25 MHz pixel clock).
//   - RGB332 colour field widths.
//   - 10-bit coordinate width and the sync/active bundle that travels down
//     the alignment delay line.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // Pin-level sync levels plus the visible-area flag for one pixel slot.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register with a per-bit reset value.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset, loads RESET_VAL into all stages
//   i_d       : WIDTH-bit input, enters stage 0
//   o_q       : WIDTH-bit output, i_d delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  // NOTE: every stage is reset, not only the last one; otherwise a reset
  // taken during a sync pulse would let stale pulse bits drain out afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage <= {DEPTH{RESET_VAL}};
    end else begin
      stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-clock timing stage: horizontal/vertical counters, coordinate outputs
// for the colour logic, and sync/colour pins aligned to the returned colour.
//   i_clk          : pixel clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   o_X, o_Y       : registered coordinates (counters one clock late)
//   o_Active       : o_X/o_Y inside the visible area
//   o_Line_Start   : pulse with o_X==0
//   o_Frame_Start  : pulse with o_X==0 and o_Y==0
//   i_Red/Green/Blue : colour for the coordinate issued PIX_LAT clocks earlier
//   HSYNC, VSYNC   : sync pins, asserted level SYNC_POL
//   o_Red/Green/Blue : colour pins, zero outside the visible area
// Sync and colour pins refer to the o_X/o_Y presented PIX_LAT+1 clocks before.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [COORD_W-1:0] o_X,
  output logic [COORD_W-1:0] o_Y,
  output logic               o_Active,
  output logic               o_Line_Start,
  output logic               o_Frame_Start,
  input  logic [RED_W-1:0]   i_Red,
  input  logic [GREEN_W-1:0] i_Green,
  input  logic [BLUE_W-1:0]  i_Blue,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic [RED_W-1:0]   o_Red,
  output logic [GREEN_W-1:0] o_Green,
  output logic [BLUE_W-1:0]  o_Blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_END = coord_t'(V_ACTIVE);
  localparam coord_t HS_START  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END    = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END    = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // Raw decode is one clock ahead of o_X/o_Y, so PIX_LAT+1 stages bring it
  // to the edge on which the matching colour is sampled.
  localparam int DLY_DEPTH = PIX_LAT + 1;

  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0};

  coord_t h;
  coord_t v;
  sync_t  raw;
  sync_t  dly;

  // ---------------------------------------------------------------------------
  // Position counters: v advances only when h wraps.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values and process order cannot change behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Raw decode of the current counter position.
  // ---------------------------------------------------------------------------
  // NOTE: raw gets a full default first so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    raw        = SYNC_IDLE;
    raw.active = (h < H_ACT_END) && (v < V_ACT_END);
    if ((h >= HS_START) && (h < HS_END)) raw.hs = SYNC_POL;
    if ((v >= VS_START) && (v < VS_END)) raw.vs = SYNC_POL;
  end

  // ---------------------------------------------------------------------------
  // Coordinate outputs, one clock behind the counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_X           <= '0;
      o_Y           <= '0;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_X           <= h;
      o_Y           <= v;
      o_Active      <= raw.active;
      o_Line_Start  <= (h == '0);
      o_Frame_Start <= (h == '0) && (v == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Align sync/active with the colour returned by the consumer.
  // ---------------------------------------------------------------------------
  vga_delay_line #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (DLY_DEPTH),
    .RESET_VAL (SYNC_IDLE)
  ) u_align (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (raw),
    .o_q     (dly)
  );

  // Pin registers. Colour sampled while the aligned slot is blanked is
  // replaced by zero, so the pins never carry whatever the consumer drives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      HSYNC   <= SYNC_IDLE.hs;
      VSYNC   <= SYNC_IDLE.vs;
      o_Red   <= '0;
      o_Green <= '0;
      o_Blue  <= '0;
    end else begin
      HSYNC   <= dly.hs;
      VSYNC   <= dly.vs;
      o_Red   <= dly.active ? i_Red   : '0;
      o_Green <= dly.active ? i_Green : '0;
      o_Blue  <= dly.active ? i_Blue  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Scoreboard bench for vga_timing_gen. Full 800-clock lines with a shortened
// 13-line frame (6 visible, 2 front porch, 2 sync, 3 back porch) so whole
// frames fit in a short run. The stimulus process pushes the expected pin
// state for every cycle; a monitor pops and compares on the falling edge.
// A second monitor measures pulse widths and spacings against fixed numbers.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_TOT   = 800;
  localparam int V_ACT   = 6;
  localparam int V_FP    = 2;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 3;
  localparam int V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;  // 13
  localparam int FRAME   = H_TOT * V_TOT;                // 10400
  localparam int PIX_LAT = 1;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [9:0] o_X, o_Y;
  logic       o_Active, o_Line_Start, o_Frame_Start, HSYNC, VSYNC;
  logic [2:0] i_Red   = '0;
  logic [2:0] i_Green = '0;
  logic [1:0] i_Blue  = '0;
  logic [2:0] o_Red, o_Green;
  logic [1:0] o_Blue;

  always #5 i_clk = ~i_clk;

  vga_timing_gen #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PIX_LAT  (PIX_LAT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_X           (o_X),
    .o_Y           (o_Y),
    .o_Active      (o_Active),
    .o_Line_Start  (o_Line_Start),
    .o_Frame_Start (o_Frame_Start),
    .i_Red         (i_Red),
    .i_Green       (i_Green),
    .i_Blue        (i_Blue),
    .HSYNC         (HSYNC),
    .VSYNC         (VSYNC),
    .o_Red         (o_Red),
    .o_Green       (o_Green),
    .o_Blue        (o_Blue)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } obs_t;

  typedef struct {
    int   k;
    obs_t v;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [9:0] ox_prev  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pins after the k-th edge since reset release (k<=0: in reset).
  // Coordinates show slot k-1; sync/colour show slot k-1-(PIX_LAT+1).
  function automatic obs_t model(input int k);
    obs_t e;
    int   c, d, xd, yd;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k >= 1) begin
      c     = k - 1;
      e.x   = 10'(c % H_TOT);
      e.y   = 10'((c / H_TOT) % V_TOT);
      e.act = ((c % H_TOT) < 640) && (((c / H_TOT) % V_TOT) < V_ACT);
      e.ls  = (c % H_TOT) == 0;
      e.fs  = (c % FRAME) == 0;
    end
    if (k >= PIX_LAT + 2) begin
      d    = k - PIX_LAT - 2;
      xd   = d % H_TOT;
      yd   = (d / H_TOT) % V_TOT;
      e.hs = !((xd >= 656) && (xd < 752));
      e.vs = !((yd >= V_ACT + V_FP) && (yd < V_ACT + V_FP + V_SYNC));
      if ((xd < 640) && (yd < V_ACT)) begin
        e.r = 3'(xd % 8);
        e.g = 3'b111;
        e.b = 2'((xd / 8) % 4);
      end
    end
    return e;
  endfunction

  // One clock of stimulus: the consumer returns colour for the coordinate
  // seen one clock earlier (PIX_LAT=1), and the expectation is queued.
  task automatic tick(input int k);
    exp_t item;
    @(posedge i_clk);
    #1;
    i_Red   = ox_prev[2:0];
    i_Green = 3'b111;
    i_Blue  = ox_prev[4:3];
    ox_prev = o_X;
    item.k  = k;
    item.v  = model(k);
    sb_q.push_back(item);
  endtask

  // Per-cycle scoreboard monitor.
  always @(negedge i_clk) begin
    exp_t e;
    obs_t a;
    if (sb_q.size() != 0) begin
      e     = sb_q.pop_front();
      a.x   = o_X;
      a.y   = o_Y;
      a.act = o_Active;
      a.ls  = o_Line_Start;
      a.fs  = o_Frame_Start;
      a.hs  = HSYNC;
      a.vs  = VSYNC;
      a.r   = o_Red;
      a.g   = o_Green;
      a.b   = o_Blue;
      check($sformatf("cycle_k%0d", e.k), 64'(a), 64'(e.v));
    end
  end

  // Pulse width / spacing monitor.
  int         hs_run = 0, vs_run = 0, g_run = 0, ls_gap = 0, fs_gap = 0;
  logic       prev_hs = 1'b1, fs_seen = 1'b0;
  logic [9:0] prev_y = '0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hs_run  = 0;
      vs_run  = 0;
      g_run   = 0;
      ls_gap  = 0;
      fs_gap  = 0;
      fs_seen = 1'b0;
      prev_hs = 1'b1;
      prev_y  = '0;
    end else begin
      if (!HSYNC) hs_run++;
      else if (hs_run != 0) begin
        check("hsync_width", 64'(hs_run), 64'd96);
        hs_run = 0;
      end
      if (!VSYNC) vs_run++;
      else if (vs_run != 0) begin
        check("vsync_width", 64'(vs_run), 64'd1600);
        vs_run = 0;
      end
      if (o_Green == 3'b111) g_run++;
      else if (g_run != 0) begin
        check("colour_run", 64'(g_run), 64'd640);
        g_run = 0;
      end
      ls_gap++;
      if (o_Line_Start) ls_gap = 0;
      if (prev_hs && !HSYNC) check("hsync_fall_offset", 64'(ls_gap), 64'd658);
      prev_hs = HSYNC;
      fs_gap++;
      if (o_Frame_Start) begin
        if (fs_seen) check("frame_period", 64'(fs_gap), 64'(FRAME));
        fs_gap  = 0;
        fs_seen = 1'b1;
      end
      if (o_Y != prev_y) begin
        check("y_step", 64'(o_Y), (prev_y == 10'(V_TOT - 1)) ? 64'd0 : 64'(prev_y + 10'd1));
        prev_y = o_Y;
      end
    end
  end

  initial begin
    // Power-up reset, 5 clocks.
    i_rst_n = 1'b0;
    for (int i = 0; i < 5; i++) tick(0);
    i_rst_n = 1'b1;

    // Run into the second frame up to o_X=700, o_Y=9 (vertical sync line).
    for (int k = 1; k <= FRAME + 9 * H_TOT + 701; k++) tick(k);
    check("pre_reset_x", 64'(o_X), 64'd700);
    check("pre_reset_y", 64'(o_Y), 64'd9);
    check("pre_reset_vsync", 64'(VSYNC), 64'd0);
    check("pre_reset_hsync", 64'(HSYNC), 64'd0);

    // Asynchronous reset mid-line, away from any clock edge.
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_hsync", 64'(HSYNC), 64'd1);
    check("async_vsync", 64'(VSYNC), 64'd1);
    check("async_x", 64'(o_X), 64'd0);
    check("async_y", 64'(o_Y), 64'd0);
    check("async_red", 64'(o_Red), 64'd0);
    for (int i = 0; i < 5; i++) tick(0);
    i_rst_n = 1'b1;

    // Restart must match power-up.
    for (int k = 1; k <= 2000; k++) tick(k);

    @(negedge i_clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-clock timing stage feeding the colour-generation logic inside Main, and driving the VGA connector pins.
- Counts horizontal and vertical position for 640x480@60 Hz at a 25 MHz pixel clock.
- Publishes pixel coordinates upstream, accepts the colour computed for those coordinates, and aligns HSYNC/VSYNC to that colour.
- Blanks the colour outside the visible area.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of HSYNC/VSYNC (0 = active-low)
- PIX_LAT, 1, clocks from o_X/o_Y valid to matching i_Red/i_Green/i_Blue valid (range 0..4)

Ports:
- i_clk  in  1  pixel clock, 25 MHz, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_X  out  10  horizontal counter, 0..H_TOTAL-1
- o_Y  out  10  vertical counter, 0..V_TOTAL-1
- o_Active  out  1  o_X/o_Y lie inside the visible area
- o_Line_Start  out  1  one-clock pulse when o_X==0
- o_Frame_Start  out  1  one-clock pulse when o_X==0 and o_Y==0
- i_Red  in  3  colour for the coordinate issued PIX_LAT clocks earlier
- i_Green  in  3  as above
- i_Blue  in  2  as above
- HSYNC  out  1  horizontal sync pin
- VSYNC  out  1  vertical sync pin
- o_Red  out  3  blanked red pin
- o_Green  out  3  blanked green pin
- o_Blue  out  2  blanked blue pin

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). Localparams derived from parameters.
- Counters h (10 b) and v (10 b):
  - h increments every clock and wraps H_TOTAL-1 -> 0.
  - v increments only on an h wrap and wraps V_TOTAL-1 -> 0 when h and v wrap together.
- Coordinate outputs are registered decodes of (h,v), lagging the counters by one clock:
  - o_X = h and o_Y = v as of the previous clock.
  - o_Active = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - o_Line_Start = (h==0); o_Frame_Start = (h==0&&v==0).
- Raw sync decode, asserted level = SYNC_POL:
  - hs_raw asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for every h on those lines.
- Alignment delay line, PIX_LAT+1 stages, carries {hs, vs, active}:
  - HSYNC, VSYNC, o_Red/o_Green/o_Blue are registered.
  - They correspond to the o_X/o_Y presented PIX_LAT+1 clocks earlier.
  - With PIX_LAT=0, the consumer drives i_* combinationally from o_X/o_Y.
- Blanking: o_Red/o_Green/o_Blue = delayed_active ? i_* sampled : 0. Blanked pins are never undefined.
- Reset (async assert, release sync to i_clk):
  - h=0, v=0.
  - o_X=0, o_Y=0, o_Active=0, o_Line_Start=0, o_Frame_Start=0.
  - HSYNC=VSYNC=~SYNC_POL; o_Red=o_Green=o_Blue=0.
  - All delay stages are reset to the inactive/deasserted state.
- First edge after release: o_X=0, o_Y=0, o_Active=1, o_Line_Start=1, o_Frame_Start=1. Counters are now h=1.
- Reset mid-frame: all outputs take reset values immediately. The restart is identical to power-up, with no partial sync pulse carried through the delay line.
- i_* values sampled while the delayed active is 0 are discarded.
- Frame period = H_TOTAL*V_TOTAL = 420000 clocks, exact and with no drift.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480 timing constants;
  - RGB332 field widths (3/3/2);
  - the 10-bit coordinate width.
- One sub-module is natural: vga_delay_line, a parameterised-depth shift register with reset value per bit, used for the sync/active alignment.
- Counters and decode stay in vga_timing_gen.

Test Plan:
- Reset held 5 clocks, released -> during reset HSYNC=1, VSYNC=1, RGB=0. First edge gives o_X=0, o_Y=0, o_Frame_Start=1, o_Active=1.
- Free-run one line (PIX_LAT=1), i_* = 3'b111/3'b111/2'b11 constant:
  - o_Active high for o_X 0..639 only.
  - o_Red=7 for exactly 640 consecutive clocks per line.
  - RGB=0 at all other times.
- HSYNC check -> low for exactly 96 clocks per line, falling edge 658 clocks after the o_Line_Start pulse (656 + PIX_LAT + 1).
- Full frame -> VSYNC low for exactly 1600 clocks (2 lines) starting on line 490. o_Frame_Start pulses are exactly 420000 clocks apart. o_Y wraps 524 -> 0.
- Consumer drives i_Red = o_X[2:0] delayed PIX_LAT -> o_Red equals the delayed o_X[2:0] pattern 0,1..7 repeating, with no one-clock skew at line start or end.
- Reset asserted mid-line at o_X=700, o_Y=491 (sync active) -> HSYNC/VSYNC return to 1 asynchronously. After release the sequence matches the first scenario.
